// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   pc_mode_e   - next-PC select encoding driven by decode/branch logic
//                 (values 6 and 7 are reserved and treated as HOLD)
//   align_bits  - number of low PC bits forced to zero for a given STEP
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_HOLD   = 3'd5
  } pc_mode_e;

  // ALIGN_BITS for a given step size; STEP is a power of two, so this is
  // also the width of the low-bit mask that keeps the PC aligned.
  function automatic int align_bits(input int step);
    return $clog2(step);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO).
//   clk, rst   - clock and asynchronous active-high reset
//   push       - write push_data at ptr, advance ptr; overwrites oldest when full
//   pop        - retreat ptr (ignored when empty); push has priority
//   push_data  - return address to store
//   top_data   - entry at ptr-1 (most recent push); meaningless when empty
//   count      - number of valid entries, 0..DEPTH
//   full/empty - count == DEPTH / count == 0
module pc_ras
  import pc_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         top_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  // ptr always points at the next free slot, so the top lives one below;
  // the pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign top_data = mem_q[ptr_q - PTR_W'(1)];

  // Pointer/count update. A push on a full stack still advances the pointer,
  // which makes the oldest entry the next one overwritten, but count saturates.
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) count_d = count_q + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr_d   = ptr_q - PTR_W'(1);
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset: contents are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with next-PC selection and a return-address stack.
//   clk, rst      - clock and asynchronous active-high reset (pc <= RESET_VEC)
//   ena           - update enable; 0 freezes all state including error flags
//   mode          - next-PC select (pc_mode_e; 6/7 reserved -> HOLD + err_mode)
//   offset        - signed byte offset for BRANCH
//   target        - absolute target for JUMP and CALL
//   clr_err       - clears sticky error flags when ena=1 (new events win)
//   pc, pc_plus   - registered PC and pc + STEP
//   ras_count/ras_empty/ras_full - return-address stack occupancy
//   err_align/err_under/err_over/err_mode - sticky error flags
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               STEP      = 4,
  parameter int               OFF_W     = 16,
  parameter int               DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [2:0]             mode,
  input  logic [OFF_W-1:0]       offset,
  input  logic [WIDTH-1:0]       target,
  input  logic                   clr_err,
  output logic [WIDTH-1:0]       pc,
  output logic [WIDTH-1:0]       pc_plus,
  output logic [$clog2(DEPTH):0] ras_count,
  output logic                   ras_empty,
  output logic                   ras_full,
  output logic                   err_align,
  output logic                   err_under,
  output logic                   err_over,
  output logic                   err_mode
);

  localparam int               ALIGN_B  = align_bits(STEP);
  localparam logic [WIDTH-1:0] LOW_MASK = (WIDTH'(1) << ALIGN_B) - WIDTH'(1);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_align_q, err_align_d;
  logic             err_under_q, err_under_d;
  logic             err_over_q, err_over_d;
  logic             err_mode_q, err_mode_d;

  logic [WIDTH-1:0] offset_sext;
  logic [WIDTH-1:0] ras_top;
  logic             ras_push, ras_pop;
  logic             align_evt, under_evt, over_evt, mode_evt;

  assign pc_plus     = pc_q + WIDTH'(STEP);
  assign offset_sext = WIDTH'($signed(offset));

  pc_ras #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus),
    .top_data  (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  // Next-PC mux and error events. Everything is gated by ena so a stall
  // leaves the PC, the stack and the flags untouched. Targets are masked
  // down to STEP alignment; the error flag records that masking happened.
  always_comb begin
    pc_d        = pc_q;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    align_evt   = 1'b0;
    under_evt   = 1'b0;
    over_evt    = 1'b0;
    mode_evt    = 1'b0;
    err_align_d = err_align_q;
    err_under_d = err_under_q;
    err_over_d  = err_over_q;
    err_mode_d  = err_mode_q;
    if (ena) begin
      case (mode)
        PC_SEQ: pc_d = pc_plus;
        PC_BRANCH: begin
          pc_d      = (pc_q + offset_sext) & ~LOW_MASK;
          align_evt = |(offset_sext & LOW_MASK);
        end
        PC_JUMP: begin
          pc_d      = target & ~LOW_MASK;
          align_evt = |(target & LOW_MASK);
        end
        PC_CALL: begin
          pc_d      = target & ~LOW_MASK;
          align_evt = |(target & LOW_MASK);
          ras_push  = 1'b1;
          over_evt  = ras_full;
        end
        PC_RET: begin
          if (!ras_empty) begin
            pc_d    = ras_top;
            ras_pop = 1'b1;
          end else begin
            // Underflow falls through sequentially rather than jumping to garbage.
            pc_d      = pc_plus;
            under_evt = 1'b1;
          end
        end
        PC_HOLD: pc_d = pc_q;
        default: mode_evt = 1'b1;
      endcase
      // Clear first, then OR in this cycle's events so a new error is never lost.
      if (clr_err) begin
        err_align_d = 1'b0;
        err_under_d = 1'b0;
        err_over_d  = 1'b0;
        err_mode_d  = 1'b0;
      end
      err_align_d = err_align_d | align_evt;
      err_under_d = err_under_d | under_evt;
      err_over_d  = err_over_d  | over_evt;
      err_mode_d  = err_mode_d  | mode_evt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_VEC;
      err_align_q <= 1'b0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
      err_mode_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      err_align_q <= err_align_d;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
      err_mode_q  <= err_mode_d;
    end
  end

  assign pc        = pc_q;
  assign err_align = err_align_q;
  assign err_under = err_under_q;
  assign err_over  = err_over_q;
  assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit (default parameters).
// Stimulus pushes the hand-computed expected state into a scoreboard queue;
// monitor processes pop and compare after each clock or after an async reset.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [2:0]  mode;
  logic [15:0] offset;
  logic [31:0] target;
  logic        clr_err;
  logic [31:0] pc;
  logic [31:0] pc_plus;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full;
  logic        err_align, err_under, err_over, err_mode;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] pc;
    int          cnt;
    logic [3:0]  err;   // {align, under, over, mode}
  } exp_t;

  exp_t sb[$];
  int   cycle  = 0;
  int   checks = 0;
  int   errors = 0;
  event check_ev;

  pc_unit dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .mode      (mode),
    .offset    (offset),
    .target    (target),
    .clr_err   (clr_err),
    .pc        (pc),
    .pc_plus   (pc_plus),
    .ras_count (ras_count),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .err_align (err_align),
    .err_under (err_under),
    .err_over  (err_over),
    .err_mode  (err_mode)
  );

  always #5 clk = ~clk;

  // Compare one field and keep the counters in step.
  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s.%s: got 0x%0h, required 0x%0h", name, field, act, req);
    end
  endtask

  // Pop every expectation that is due by now_cyc and compare it against the DUT.
  task automatic checkOutput(input int now_cyc);
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= now_cyc) begin
      e = sb.pop_front();
      cmp(e.name, "pc",        pc,                 e.pc);
      cmp(e.name, "pc_plus",   pc_plus,            e.pc + 32'd4);
      cmp(e.name, "ras_count", {29'd0, ras_count}, 32'(e.cnt));
      cmp(e.name, "ras_empty", {31'd0, ras_empty}, {31'd0, e.cnt == 0});
      cmp(e.name, "ras_full",  {31'd0, ras_full},  {31'd0, e.cnt == 4});
      cmp(e.name, "err",
          {28'd0, err_align, err_under, err_over, err_mode}, {28'd0, e.err});
    end
  endtask

  // Clocked monitor: results of the posedge are checked on the following negedge.
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      checkOutput(cycle);
    end
  end

  // Asynchronous monitor: checks expectations posted outside the clock.
  initial begin
    forever begin
      @(check_ev);
      checkOutput(cycle);
    end
  end

  // Drive one operation for one clock and post its expected result.
  task automatic applyStimulus(input string name, input logic e, input logic [2:0] m,
                               input logic [15:0] off, input logic [31:0] tgt,
                               input logic clr, input logic [31:0] epc,
                               input int ecnt, input logic [3:0] eerr);
    exp_t x;
    @(negedge clk);
    #1;
    ena     = e;
    mode    = m;
    offset  = off;
    target  = tgt;
    clr_err = clr;
    x.cyc  = cycle + 1;
    x.name = name;
    x.pc   = epc;
    x.cnt  = ecnt;
    x.err  = eerr;
    sb.push_back(x);
  endtask

  // Raise rst between clock edges, check the reset state right away, release later.
  task automatic applyAsyncReset(input string name);
    exp_t x;
    @(negedge clk);
    #1;
    rst = 1'b1;
    ena = 1'b0;
    #1;
    x.cyc  = cycle;
    x.name = name;
    x.pc   = 32'h0;
    x.cnt  = 0;
    x.err  = 4'b0000;
    sb.push_back(x);
    ->check_ev;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; ena = 1'b0; mode = 3'd0; offset = '0; target = '0; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    applyAsyncReset("reset_state");

    applyStimulus("seq1", 1, 3'd0, 16'h0, 32'h0, 0, 32'h4, 0, 4'b0000);
    applyStimulus("seq2", 1, 3'd0, 16'h0, 32'h0, 0, 32'h8, 0, 4'b0000);
    applyStimulus("seq3", 1, 3'd0, 16'h0, 32'h0, 0, 32'hC, 0, 4'b0000);
    applyAsyncReset("rst_mid");

    applyStimulus("jump100",   1, 3'd2, 16'h0,    32'h100, 0, 32'h100, 0, 4'b0000);
    applyStimulus("br_neg8",   1, 3'd1, 16'hFFF8, 32'h0,   0, 32'hF8,  0, 4'b0000);
    applyStimulus("br_mis6",   1, 3'd1, 16'h0006, 32'h0,   0, 32'hFC,  0, 4'b1000);
    applyStimulus("clr_align", 1, 3'd5, 16'h0,    32'h0,   1, 32'hFC,  0, 4'b0000);

    applyStimulus("stall1", 0, 3'd2, 16'h0, 32'h4000, 0, 32'hFC,   0, 4'b0000);
    applyStimulus("stall2", 0, 3'd2, 16'h0, 32'h4000, 0, 32'hFC,   0, 4'b0000);
    applyStimulus("unstall",1, 3'd2, 16'h0, 32'h4000, 0, 32'h4000, 0, 4'b0000);

    applyStimulus("jump10",  1, 3'd2, 16'h0, 32'h10,  0, 32'h10,  0, 4'b0000);
    applyStimulus("call200", 1, 3'd3, 16'h0, 32'h200, 0, 32'h200, 1, 4'b0000);
    applyStimulus("call300", 1, 3'd3, 16'h0, 32'h300, 0, 32'h300, 2, 4'b0000);
    applyStimulus("ret1",    1, 3'd4, 16'h0, 32'h0,   0, 32'h204, 1, 4'b0000);
    applyStimulus("ret2",    1, 3'd4, 16'h0, 32'h0,   0, 32'h14,  0, 4'b0000);
    applyStimulus("ret_und", 1, 3'd4, 16'h0, 32'h0,   0, 32'h18,  0, 4'b0100);
    applyStimulus("clr_und", 1, 3'd5, 16'h0, 32'h0,   1, 32'h18,  0, 4'b0000);

    applyStimulus("jump0",   1, 3'd2, 16'h0, 32'h0,   0, 32'h0,   0, 4'b0000);
    applyStimulus("ovc1",    1, 3'd3, 16'h0, 32'h100, 0, 32'h100, 1, 4'b0000);
    applyStimulus("ovc2",    1, 3'd3, 16'h0, 32'h200, 0, 32'h200, 2, 4'b0000);
    applyStimulus("ovc3",    1, 3'd3, 16'h0, 32'h300, 0, 32'h300, 3, 4'b0000);
    applyStimulus("ovc4",    1, 3'd3, 16'h0, 32'h400, 0, 32'h400, 4, 4'b0000);
    applyStimulus("ovc5",    1, 3'd3, 16'h0, 32'h500, 0, 32'h500, 4, 4'b0010);
    applyStimulus("ovr1",    1, 3'd4, 16'h0, 32'h0,   0, 32'h404, 3, 4'b0010);
    applyStimulus("ovr2",    1, 3'd4, 16'h0, 32'h0,   0, 32'h304, 2, 4'b0010);
    applyStimulus("ovr3",    1, 3'd4, 16'h0, 32'h0,   0, 32'h204, 1, 4'b0010);
    applyStimulus("ovr4",    1, 3'd4, 16'h0, 32'h0,   0, 32'h104, 0, 4'b0010);
    applyStimulus("clr_ovr", 1, 3'd5, 16'h0, 32'h0,   1, 32'h104, 0, 4'b0000);

    applyStimulus("jump_top",  1, 3'd2, 16'h0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 0, 4'b0000);
    applyStimulus("seq_wrap",  1, 3'd0, 16'h0, 32'h0,         0, 32'h0,         0, 4'b0000);
    applyStimulus("mode7",     1, 3'd7, 16'h0, 32'h0,         0, 32'h0,         0, 4'b0001);
    applyStimulus("stall_clr", 0, 3'd0, 16'h0, 32'h0,         1, 32'h0,         0, 4'b0001);
    applyStimulus("set_wins",  1, 3'd6, 16'h0, 32'h0,         1, 32'h0,         0, 4'b0001);
    applyStimulus("clr_mode",  1, 3'd5, 16'h0, 32'h0,         1, 32'h0,         0, 4'b0000);

    applyStimulus("jump_mis",  1, 3'd2, 16'h0, 32'h1002, 0, 32'h1000, 0, 4'b1000);
    applyStimulus("call_mis",  1, 3'd3, 16'h0, 32'h2001, 0, 32'h2000, 1, 4'b1000);
    applyStimulus("ret_mis",   1, 3'd4, 16'h0, 32'h0,    0, 32'h1004, 0, 4'b1000);
    applyStimulus("call3000",  1, 3'd3, 16'h0, 32'h3000, 0, 32'h3000, 1, 4'b1000);
    applyAsyncReset("rst_clears");
    applyStimulus("seq_after", 1, 3'd0, 16'h0, 32'h0,    0, 32'h4,    0, 4'b0000);

    @(negedge clk);
    #1;
    ena = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
